// File: rtl/perf_counter_bank.sv
// Parametrised bank of event counters with a CSR-side read/write port and split readout of wide counters.
// Optional sticky overflow flags and interrupt are built only when PERF_CNT_OVF_EN is defined.
module perf_counter_bank #(
    parameter int NUM_CNT = 8,
    parameter int CNT_W   = 64,
    parameter int XLEN    = 32,
    parameter int INC     = 1,
    parameter int IDX_W   = $clog2(NUM_CNT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CNT-1:0] evt_i,
    input  logic [NUM_CNT-1:0] inhibit_i,
    input  logic               clear_i,
    input  logic               rd_en_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    input  logic               rd_hi_i,
    output logic [XLEN-1:0]    rd_data_o,
    output logic               rd_valid_o,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic               wr_hi_i,
    input  logic [XLEN-1:0]    wr_data_i,
    output logic [NUM_CNT-1:0] ovf_o,
    input  logic [NUM_CNT-1:0] ovf_clr_i,
    output logic               irq_o
);

    localparam int unsigned PAD_N = 1 << IDX_W;
    localparam bit          WIDE  = (CNT_W > XLEN);

    logic [CNT_W-1:0]   r_cnt     [NUM_CNT];
    logic [CNT_W-1:0]   w_nxt     [NUM_CNT];
    logic [CNT_W-1:0]   w_wr_val  [NUM_CNT];
    logic [CNT_W-1:0]   w_cnt_pad [PAD_N];
    logic [CNT_W-1:0]   w_rd_cnt;
    logic [CNT_W:0]     w_sum;
    logic [NUM_CNT-1:0] w_wr_hit;
    logic [NUM_CNT-1:0] w_wrap;
    logic [XLEN-1:0]    w_lo_rd;
    logic [XLEN-1:0]    w_hi_rd;
    logic [XLEN-1:0]    r_rd_data;
    logic               r_rd_valid;

    // Out-of-range indices land on zero-filled padding, so reads of them return 0.
    always_comb begin
        for (int unsigned i = 0; i < PAD_N; i++) w_cnt_pad[i] = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) w_cnt_pad[i] = r_cnt[i];
        w_rd_cnt = w_cnt_pad[rd_idx_i];
    end

    generate
        if (CNT_W > XLEN) begin : g_wide
            localparam int HI_W = CNT_W - XLEN;
            logic [HI_W-1:0] r_shadow;

            always_comb begin
                for (int unsigned k = 0; k < NUM_CNT; k++) begin
                    if (wr_hi_i) w_wr_val[k] = {wr_data_i[HI_W-1:0], r_cnt[k][XLEN-1:0]};
                    else         w_wr_val[k] = {r_cnt[k][CNT_W-1:XLEN], wr_data_i};
                end
            end

            // A lo read latches the upper half of the same pre-update sample for the following hi read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                    r_shadow <= '0;
                else if (clear_i)              r_shadow <= '0;
                else if (rd_en_i && !rd_hi_i)  r_shadow <= w_rd_cnt[CNT_W-1:XLEN];
            end

            always_comb begin
                w_lo_rd              = w_rd_cnt[XLEN-1:0];
                w_hi_rd              = '0;
                w_hi_rd[HI_W-1:0]    = r_shadow;
            end
        end else begin : g_narrow
            always_comb begin
                for (int unsigned k = 0; k < NUM_CNT; k++) w_wr_val[k] = wr_data_i[CNT_W-1:0];
            end

            always_comb begin
                w_lo_rd              = '0;
                w_lo_rd[CNT_W-1:0]   = w_rd_cnt;
                w_hi_rd              = '0;
            end
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int unsigned k = 0; k < NUM_CNT; k++) begin
            w_wr_hit[k] = wr_en_i && (wr_idx_i == IDX_W'(k)) && (WIDE || !wr_hi_i);
            w_sum       = {1'b0, r_cnt[k]} + (CNT_W+1)'(INC);
            w_nxt[k]    = r_cnt[k];
            w_wrap[k]   = 1'b0;
            if (clear_i) begin
                w_nxt[k] = '0;
            end else if (w_wr_hit[k]) begin
                w_nxt[k] = w_wr_val[k];
            end else if (evt_i[k] && !inhibit_i[k]) begin
                w_nxt[k]  = w_sum[CNT_W-1:0];
                w_wrap[k] = w_sum[CNT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CNT; k++) r_cnt[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_CNT; k++) r_cnt[k] <= w_nxt[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en_i;
            if (rd_en_i) r_rd_data <= rd_hi_i ? w_hi_rd : w_lo_rd;
        end
    end

    assign rd_data_o  = r_rd_data;
    assign rd_valid_o = r_rd_valid;

`ifdef PERF_CNT_OVF_EN
    logic [NUM_CNT-1:0] r_ovf;

    // A wrap on the same edge as a clear request wins, so no overflow is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ovf <= '0;
        else        r_ovf <= (r_ovf & ~ovf_clr_i) | w_wrap;
    end

    assign ovf_o = r_ovf;
    assign irq_o = |r_ovf;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = ^{ovf_clr_i, w_wrap};
    assign ovf_o        = '0;
    assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank (6 channels so out-of-range indices are reachable).
// Overflow expectations follow PERF_CNT_OVF_EN when it is defined for the build.
module tb_perf_counter_bank;

    localparam int NUM_CNT = 6;
    localparam int XLEN    = 32;
    localparam int IDX_W   = 3;
`ifdef PERF_CNT_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_CNT-1:0] evt_i, inhibit_i, ovf_clr_i, ovf_o;
    logic               clear_i, rd_en_i, rd_hi_i, wr_en_i, wr_hi_i, rd_valid_o, irq_o;
    logic [IDX_W-1:0]   rd_idx_i, wr_idx_i;
    logic [XLEN-1:0]    wr_data_i, rd_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    perf_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_W(64), .XLEN(XLEN), .INC(1)) dut (
        .clk(clk), .rst_n(rst_n), .evt_i(evt_i), .inhibit_i(inhibit_i), .clear_i(clear_i),
        .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_hi_i(rd_hi_i), .rd_data_o(rd_data_o),
        .rd_valid_o(rd_valid_o), .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_hi_i(wr_hi_i),
        .wr_data_i(wr_data_i), .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int idx, input bit hi, output logic [31:0] d, output logic v);
        rd_en_i  = 1'b1;
        rd_idx_i = idx[IDX_W-1:0];
        rd_hi_i  = hi;
        tick();
        d        = rd_data_o;
        v        = rd_valid_o;
        rd_en_i  = 1'b0;
    endtask

    task automatic wr(input int idx, input bit hi, input logic [31:0] data);
        wr_en_i   = 1'b1;
        wr_idx_i  = idx[IDX_W-1:0];
        wr_hi_i   = hi;
        wr_data_i = data;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        rst_n = 1'b0;
        evt_i = '0; inhibit_i = '0; ovf_clr_i = '0;
        clear_i = 1'b0; rd_en_i = 1'b0; rd_hi_i = 1'b0; wr_en_i = 1'b0; wr_hi_i = 1'b0;
        rd_idx_i = '0; wr_idx_i = '0; wr_data_i = '0;
        #2;
        n_tests++;
        if (rd_data_o !== 32'h0 || rd_valid_o !== 1'b0 || ovf_o !== '0 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h valid=%b ovf=%b irq=%b, want 0/0/0/0",
                     rd_data_o, rd_valid_o, ovf_o, irq_o);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        rd(0, 1'b0, d, v);
        n_tests++;
        if (v !== 1'b1 || d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_counter: valid=%b data=%h, want 1/00000000", v, d);
        end
        tick();
    endtask

    task automatic test_count();
        logic [31:0] d; logic v;
        evt_i[0] = 1'b1;
        repeat (5) tick();
        evt_i[0] = 1'b0;
        n_tests++;
        if (rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL count_idle_valid: valid=%b, want 0", rd_valid_o);
        end
        rd(0, 1'b0, d, v);
        n_tests++;
        if (v !== 1'b1 || d !== 32'd5) begin
            n_fail++;
            $display("FAIL count_read: valid=%b data=%h, want 1/00000005", v, d);
        end
        tick();
        n_tests++;
        if (rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL count_valid_single: valid=%b one cycle later, want 0", rd_valid_o);
        end
    endtask

    task automatic test_split_write();
        logic [31:0] d; logic v;
        wr(2, 1'b0, 32'hFFFF_FFFE);
        wr(2, 1'b1, 32'h0000_0001);
        evt_i[2] = 1'b1;
        repeat (3) tick();
        evt_i[2] = 1'b0;
        rd(2, 1'b0, d, v);
        n_tests++;
        if (v !== 1'b1 || d !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL split_lo: valid=%b data=%h, want 1/00000001", v, d);
        end
        rd(2, 1'b1, d, v);
        n_tests++;
        if (v !== 1'b1 || d !== 32'h0000_0002) begin
            n_fail++;
            $display("FAIL split_hi: valid=%b data=%h, want 1/00000002", v, d);
        end
    endtask

    task automatic test_shadow();
        logic [31:0] d; logic v;
        wr(1, 1'b1, 32'h10);
        rd(1, 1'b0, d, v);
        wr(1, 1'b1, 32'h20);
        rd(5, 1'b1, d, v);
        n_tests++;
        if (v !== 1'b1 || d !== 32'h10) begin
            n_fail++;
            $display("FAIL shadow_hold: valid=%b data=%h, want 1/00000010", v, d);
        end
        rd(1, 1'b0, d, v);
        rd(1, 1'b1, d, v);
        n_tests++;
        if (v !== 1'b1 || d !== 32'h20) begin
            n_fail++;
            $display("FAIL shadow_fresh: valid=%b data=%h, want 1/00000020", v, d);
        end
    endtask

    task automatic test_inhibit_and_write();
        logic [31:0] d; logic v;
        wr(3, 1'b0, 32'h33);
        inhibit_i[3] = 1'b1;
        evt_i[3]     = 1'b1;
        repeat (10) tick();
        evt_i[3]     = 1'b0;
        inhibit_i[3] = 1'b0;
        rd(3, 1'b0, d, v);
        n_tests++;
        if (d !== 32'h33) begin
            n_fail++;
            $display("FAIL inhibit: data=%h, want 00000033", d);
        end
        evt_i[4] = 1'b1;
        wr(4, 1'b0, 32'h100);
        evt_i[4] = 1'b0;
        rd(4, 1'b0, d, v);
        n_tests++;
        if (d !== 32'h100) begin
            n_fail++;
            $display("FAIL write_beats_event: data=%h, want 00000100", d);
        end
        // read and write of the same counter on one edge
        rd_en_i = 1'b1; rd_idx_i = 3'd4; rd_hi_i = 1'b0;
        wr_en_i = 1'b1; wr_idx_i = 3'd4; wr_hi_i = 1'b0; wr_data_i = 32'h200;
        tick();
        rd_en_i = 1'b0; wr_en_i = 1'b0;
        n_tests++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== 32'h100) begin
            n_fail++;
            $display("FAIL read_pre_update: valid=%b data=%h, want 1/00000100", rd_valid_o, rd_data_o);
        end
        rd(4, 1'b0, d, v);
        n_tests++;
        if (d !== 32'h200) begin
            n_fail++;
            $display("FAIL read_post_write: data=%h, want 00000200", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        int          idx   [3];
        bit          hi    [3];
        exp_d = '{32'd5, 32'd1, 32'd2};
        idx   = '{0, 2, 2};
        hi    = '{1'b0, 1'b0, 1'b1};
        rd_en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_idx_i = idx[i][IDX_W-1:0];
            rd_hi_i  = hi[i];
            tick();
            n_tests++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== exp_d[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: valid=%b data=%h, want 1/%h", i, rd_valid_o, rd_data_o, exp_d[i]);
            end
        end
        rd_en_i = 1'b0;
        tick();
        n_tests++;
        if (rd_valid_o !== 1'b0 || rd_data_o !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_hold: valid=%b data=%h, want 0/00000002", rd_valid_o, rd_data_o);
        end
    endtask

    task automatic test_clear();
        logic [31:0] d; logic v;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        rd(2, 1'b1, d, v);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_shadow: data=%h, want 00000000", d);
        end
        rd(2, 1'b0, d, v);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_counter: data=%h, want 00000000", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic v;
        logic [NUM_CNT-1:0] exp_ovf;
        exp_ovf = OVF_EN ? 6'b100000 : 6'b000000;
        wr(5, 1'b0, 32'hFFFF_FFFF);
        wr(5, 1'b1, 32'hFFFF_FFFF);
        n_tests++;
        if (ovf_o !== '0) begin
            n_fail++;
            $display("FAIL ovf_write_no_set: ovf=%b, want 000000", ovf_o);
        end
        evt_i[5] = 1'b1;
        tick();
        evt_i[5] = 1'b0;
        n_tests++;
        if (ovf_o !== exp_ovf || irq_o !== OVF_EN) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b irq=%b, want %b/%b", ovf_o, irq_o, exp_ovf, OVF_EN);
        end
        rd(5, 1'b0, d, v);
        rd(5, 1'b1, d, v);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_value: hi=%h, want 00000000", d);
        end
        wr(5, 1'b0, 32'hFFFF_FFFF);
        wr(5, 1'b1, 32'hFFFF_FFFF);
        evt_i[5]     = 1'b1;
        ovf_clr_i[5] = 1'b1;
        tick();
        evt_i[5]     = 1'b0;
        n_tests++;
        if (ovf_o !== exp_ovf || irq_o !== OVF_EN) begin
            n_fail++;
            $display("FAIL ovf_set_beats_clr: ovf=%b irq=%b, want %b/%b", ovf_o, irq_o, exp_ovf, OVF_EN);
        end
        tick();
        ovf_clr_i[5] = 1'b0;
        n_tests++;
        if (ovf_o !== '0 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: ovf=%b irq=%b, want 000000/0", ovf_o, irq_o);
        end
    endtask

    task automatic test_range();
        logic [31:0] d; logic v;
        for (int i = NUM_CNT; i < 8; i++) begin
            rd(i, 1'b0, d, v);
            n_tests++;
            if (v !== 1'b1 || d !== 32'h0) begin
                n_fail++;
                $display("FAIL range_idx%0d: valid=%b data=%h, want 1/00000000", i, v, d);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic v;
        evt_i[0] = 1'b1;
        repeat (4) tick();
        evt_i[0] = 1'b0;
        rd(0, 1'b0, d, v);
        n_tests++;
        if (d !== 32'd4) begin
            n_fail++;
            $display("FAIL pre_reset_count: data=%h, want 00000004", d);
        end
        rd_en_i = 1'b1; rd_idx_i = '0; rd_hi_i = 1'b0;
        evt_i[0] = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if (rd_data_o !== 32'h0 || rd_valid_o !== 1'b0 || ovf_o !== '0 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: data=%h valid=%b ovf=%b irq=%b, want 0/0/0/0",
                     rd_data_o, rd_valid_o, ovf_o, irq_o);
        end
        tick();
        #2;
        rd_en_i  = 1'b0;
        evt_i[0] = 1'b0;
        rst_n    = 1'b1;
        tick();
        n_tests++;
        if (rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drops_read: valid=%b, want 0", rd_valid_o);
        end
        rd(0, 1'b0, d, v);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL post_reset_count: data=%h, want 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_split_write();
        test_shadow();
        test_inhibit_and_write();
        test_back_to_back();
        test_clear();
        test_overflow();
        test_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
